mc_control_fsm: RTL and testbench
=================================

MC_CONTROL_FSM -- requirements
Module: mc_control_fsm

Interface
REQ-001 The block SHALL have these ports; clock and reset SHALL be the single clock `clk` and reset `rst`, with `rst` synchronous and active-high.
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- instr_op  in  6  opcode of the instruction register (bits 31:26)
- mem_ready  in  1  memory completes the current access this cycle
- pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a  out  1 each  datapath controls
- alu_src_b  out  2  ALU B select: 00 reg B, 01 const 4, 10 sign-extended imm, 11 imm<<2
- alu_op  out  2  00 add, 01 sub, 10 funct-decoded; feeds the existing ALU control unit
- pc_source  out  2  00 ALU result, 01 ALUOut, 10 jump target
- state  out  4  current state code (debug)
- instr_done  out  1  one-cycle pulse when an instruction retires
- illegal_op  out  1  one-cycle pulse on an undefined opcode
- retired_cnt  out  16  count of retired instructions

Function
REQ-002 States SHALL be FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, R_EXEC, R_WB, BEQ, JUMP, ADDI_EXEC, ADDI_WB.
REQ-003 FETCH SHALL drive mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00; ir_write=pc_write=mem_ready; it SHALL stay in FETCH while mem_ready=0 and go to DECODE when it is 1.
REQ-004 DECODE SHALL drive alu_src_a=0, alu_src_b=11, alu_op=00, then branch on instr_op: 100011/101011->MEM_ADDR, 000000->R_EXEC, 000100->BEQ, 000010->JUMP, 001000->ADDI_EXEC; any other opcode->FETCH with illegal_op=1 for that cycle.
REQ-005 MEM_ADDR SHALL drive alu_src_a=1, alu_src_b=10, alu_op=00, then go to MEM_RD for lw or MEM_WR for sw.
REQ-006 MEM_RD SHALL drive mem_read=1, i_or_d=1 and hold until mem_ready=1, then go to MEM_WB; MEM_WB SHALL drive reg_write=1, mem_to_reg=1, reg_dst=0.
REQ-007 MEM_WR SHALL drive mem_write=1, i_or_d=1 and hold until mem_ready=1; it retires on that cycle.
REQ-008 R_EXEC SHALL drive alu_src_a=1, alu_src_b=00, alu_op=10; R_WB SHALL drive reg_write=1, reg_dst=1, mem_to_reg=0.
REQ-009 BEQ SHALL drive alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01.
REQ-010 JUMP SHALL drive pc_write=1, pc_source=10.
REQ-011 ADDI_EXEC SHALL drive alu_src_a=1, alu_src_b=10, alu_op=00; ADDI_WB SHALL drive reg_write=1, reg_dst=0, mem_to_reg=0.
REQ-012 Retiring states (MEM_WB, MEM_WR with mem_ready=1, R_WB, BEQ, JUMP, ADDI_WB) SHALL go to FETCH, pulse instr_done and increment retired_cnt by 1 in the next cycle.
REQ-013 Any control output not listed for a state SHALL be 0; outputs SHALL be decoded from the registered state plus mem_ready only (no other input-to-output path).
REQ-014 With mem_ready held at 1, latency SHALL be: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3 cycles from FETCH entry to FETCH re-entry.
REQ-015 retired_cnt SHALL wrap from 0xFFFF to 0x0000 without flagging.
REQ-016 An illegal opcode SHALL NOT increment retired_cnt or pulse instr_done.
REQ-017 instr_op SHALL be sampled only in DECODE and MEM_ADDR; changes in other states SHALL have no effect.

Reset
REQ-018 While rst=1, all control outputs, instr_done and illegal_op SHALL be 0, state SHALL be FETCH on the next edge, and retired_cnt SHALL be 0.
REQ-019 rst asserted mid-instruction, including during a mem_ready stall, SHALL abandon the instruction without a retire pulse or count.

Structure
REQ-020 State encodings, opcode constants, and alu_op/alu_src_b/pc_source codes SHALL live in shared package mc_ctrl_pkg.
REQ-021 The block SHALL be a single module with no sub-modules; alu_op feeds the existing ALU control unit externally.

Verification
REQ-022 The bench SHALL cover these scenarios:
- lw (100011), mem_ready=1: state sequence FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, FETCH; reg_write=1 and mem_to_reg=1 in MEM_WB; retired_cnt 0->1.
- sw with mem_ready=0 for 3 cycles in MEM_WR: mem_write held at 1 for 4 cycles; one instr_done pulse.
- R-type then beq then j: alu_op sequence 10, 01; pc_write_cond=1 only in BEQ; pc_source=10 in JUMP; retired_cnt=3.
- Opcode 111111: illegal_op pulses in DECODE; returns to FETCH; retired_cnt unchanged.
- rst=1 during MEM_RD stall: next state FETCH, all outputs 0 while rst=1, retired_cnt=0.
- Preload retired_cnt=0xFFFF via 65535 addi instructions and retire one more: retired_cnt=0x0000.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control FSM: state codes, opcodes
// and the select codes driven onto the datapath muxes and ALU control unit.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH     = 4'd0,
    DECODE    = 4'd1,
    MEM_ADDR  = 4'd2,
    MEM_RD    = 4'd3,
    MEM_WB    = 4'd4,
    MEM_WR    = 4'd5,
    R_EXEC    = 4'd6,
    R_WB      = 4'd7,
    BEQ       = 4'd8,
    JUMP      = 4'd9,
    ADDI_EXEC = 4'd10,
    ADDI_WB   = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

  localparam logic [1:0] SRC_B_REG      = 2'b00;
  localparam logic [1:0] SRC_B_FOUR     = 2'b01;
  localparam logic [1:0] SRC_B_IMM      = 2'b10;
  localparam logic [1:0] SRC_B_IMM_SHL2 = 2'b11;

  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
  } ctrl_t;

endpackage

// File: rtl/mc_control_fsm.sv
// Multi-cycle MIPS main control FSM: sequences fetch/decode/execute/writeback,
// drives datapath controls from the registered state and counts retirements.
module mc_control_fsm
  import mc_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  instr_op,
  input  logic        mem_ready,
  output logic        pc_write,
  output logic        pc_write_cond,
  output logic        i_or_d,
  output logic        mem_read,
  output logic        mem_write,
  output logic        ir_write,
  output logic        mem_to_reg,
  output logic        reg_dst,
  output logic        reg_write,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  alu_op,
  output logic [1:0]  pc_source,
  output logic [3:0]  state,
  output logic        instr_done,
  output logic        illegal_op,
  output logic [15:0] retired_cnt
);

  state_t      state_q, state_d;
  ctrl_t       ctrl, ctrl_out;
  logic        retire, illegal;
  logic        done_q;
  logic [15:0] cnt_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH;
      done_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= retire;
      cnt_q   <= cnt_q + 16'(retire);
    end
  end

  // NOTE: every variable gets a default first so no path through the case infers a latch.
  always_comb begin
    state_d = state_q;
    ctrl    = '0;
    retire  = 1'b0;
    illegal = 1'b0;
    unique case (state_q)
      FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRC_B_FOUR;
        ctrl.alu_op    = ALU_OP_ADD;
        ctrl.pc_source = PC_SRC_ALU;
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
        if (mem_ready) state_d = DECODE;
      end
      DECODE: begin
        ctrl.alu_src_b = SRC_B_IMM_SHL2;
        case (instr_op)
          OP_LW, OP_SW: state_d = MEM_ADDR;
          OP_RTYPE:     state_d = R_EXEC;
          OP_BEQ:       state_d = BEQ;
          OP_J:         state_d = JUMP;
          OP_ADDI:      state_d = ADDI_EXEC;
          default: begin
            illegal = 1'b1;
            state_d = FETCH;
          end
        endcase
      end
      MEM_ADDR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRC_B_IMM;
        state_d        = (instr_op == OP_SW) ? MEM_WR : MEM_RD;
      end
      MEM_RD: begin
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = 1'b1;
        if (mem_ready) state_d = MEM_WB;
      end
      MEM_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        retire          = 1'b1;
        state_d         = FETCH;
      end
      MEM_WR: begin
        ctrl.mem_write = 1'b1;
        ctrl.i_or_d    = 1'b1;
        if (mem_ready) begin
          retire  = 1'b1;
          state_d = FETCH;
        end
      end
      R_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRC_B_REG;
        ctrl.alu_op    = ALU_OP_FUNCT;
        state_d        = R_WB;
      end
      R_WB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
        retire         = 1'b1;
        state_d        = FETCH;
      end
      BEQ: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRC_B_REG;
        ctrl.alu_op        = ALU_OP_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PC_SRC_ALUOUT;
        retire             = 1'b1;
        state_d            = FETCH;
      end
      JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PC_SRC_JUMP;
        retire         = 1'b1;
        state_d        = FETCH;
      end
      ADDI_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRC_B_IMM;
        ctrl.alu_op    = ALU_OP_ADD;
        state_d        = ADDI_WB;
      end
      ADDI_WB: begin
        ctrl.reg_write = 1'b1;
        retire         = 1'b1;
        state_d        = FETCH;
      end
      default: state_d = FETCH;
    endcase
  end

  // Reset is synchronous, so outputs are forced quiet for the whole time rst is high.
  assign ctrl_out      = rst ? '0 : ctrl;
  assign pc_write      = ctrl_out.pc_write;
  assign pc_write_cond = ctrl_out.pc_write_cond;
  assign i_or_d        = ctrl_out.i_or_d;
  assign mem_read      = ctrl_out.mem_read;
  assign mem_write     = ctrl_out.mem_write;
  assign ir_write      = ctrl_out.ir_write;
  assign mem_to_reg    = ctrl_out.mem_to_reg;
  assign reg_dst       = ctrl_out.reg_dst;
  assign reg_write     = ctrl_out.reg_write;
  assign alu_src_a     = ctrl_out.alu_src_a;
  assign alu_src_b     = ctrl_out.alu_src_b;
  assign alu_op        = ctrl_out.alu_op;
  assign pc_source     = ctrl_out.pc_source;
  assign state         = state_q;
  assign instr_done    = done_q & ~rst;
  assign illegal_op    = illegal & ~rst;
  assign retired_cnt   = rst ? '0 : cnt_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Self-checking bench for mc_control_fsm: per-instruction state paths and
// control-pulse tallies predicted from the instruction rules, plus random streams.
module tb_mc_control_fsm;
  import mc_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  instr_op;
  logic        mem_ready;
  logic        pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic        mem_to_reg, reg_dst, reg_write, alu_src_a;
  logic [1:0]  alu_src_b, alu_op, pc_source;
  logic [3:0]  state;
  logic        instr_done, illegal_op;
  logic [15:0] retired_cnt;

  mc_control_fsm dut (
    .clk(clk), .rst(rst), .instr_op(instr_op), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .state(state), .instr_done(instr_done),
    .illegal_op(illegal_op), .retired_cnt(retired_cnt)
  );

  always #5 clk = ~clk;

  int          tests = 0;
  int          fails = 0;
  logic [15:0] model_cnt = '0;
  bit          pending_done = 1'b0;

  // Inputs change 1 time unit after the edge; outputs are sampled 1 unit later.
  task automatic step(input bit rdy, input logic [5:0] op);
    @(posedge clk);
    #1;
    mem_ready = rdy;
    instr_op  = op;
    #1;
  endtask

  function automatic logic [15:0] ctrl_bus();
    return {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, mem_to_reg,
            reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source};
  endfunction

  // One instruction from FETCH entry to its last cycle; sf/sm are stall cycles
  // in FETCH and in the memory access state.
  task automatic run_instr(input logic [5:0] op, input int sf, input int sm);
    state_t plan[$];
    bit     rdy[$];
    bit     legal, is_lw, is_sw, is_r, is_beq, is_j, is_addi;
    int     exp_c[15];
    int     obs_c[15];
    string  names[15] = '{"mem_read", "mem_write", "i_or_d", "ir_write", "pc_write",
                          "pc_write_cond", "reg_write", "mem_to_reg", "reg_dst",
                          "alu_op_funct", "alu_op_sub", "pc_source_jump", "illegal_op",
                          "instr_done", "alu_src_a"};
    is_lw   = (op == OP_LW);
    is_sw   = (op == OP_SW);
    is_r    = (op == OP_RTYPE);
    is_beq  = (op == OP_BEQ);
    is_j    = (op == OP_J);
    is_addi = (op == OP_ADDI);
    legal   = is_lw | is_sw | is_r | is_beq | is_j | is_addi;

    for (int i = 0; i < sf; i++) begin plan.push_back(FETCH); rdy.push_back(1'b0); end
    plan.push_back(FETCH);  rdy.push_back(1'b1);
    plan.push_back(DECODE); rdy.push_back(1'($urandom));
    if (is_lw || is_sw) begin
      plan.push_back(MEM_ADDR); rdy.push_back(1'($urandom));
      for (int i = 0; i < sm; i++) begin
        plan.push_back(is_lw ? MEM_RD : MEM_WR); rdy.push_back(1'b0);
      end
      plan.push_back(is_lw ? MEM_RD : MEM_WR); rdy.push_back(1'b1);
      if (is_lw) begin plan.push_back(MEM_WB); rdy.push_back(1'($urandom)); end
    end else if (is_r) begin
      plan.push_back(R_EXEC); rdy.push_back(1'($urandom));
      plan.push_back(R_WB);   rdy.push_back(1'($urandom));
    end else if (is_beq) begin
      plan.push_back(BEQ);    rdy.push_back(1'($urandom));
    end else if (is_j) begin
      plan.push_back(JUMP);   rdy.push_back(1'($urandom));
    end else if (is_addi) begin
      plan.push_back(ADDI_EXEC); rdy.push_back(1'($urandom));
      plan.push_back(ADDI_WB);   rdy.push_back(1'($urandom));
    end

    exp_c[0]  = sf + 1 + (is_lw ? sm + 1 : 0);
    exp_c[1]  = is_sw ? sm + 1 : 0;
    exp_c[2]  = (is_lw || is_sw) ? sm + 1 : 0;
    exp_c[3]  = 1;
    exp_c[4]  = 1 + int'(is_j);
    exp_c[5]  = int'(is_beq);
    exp_c[6]  = int'(is_lw || is_r || is_addi);
    exp_c[7]  = int'(is_lw);
    exp_c[8]  = int'(is_r);
    exp_c[9]  = int'(is_r);
    exp_c[10] = int'(is_beq);
    exp_c[11] = int'(is_j);
    exp_c[12] = int'(!legal);
    exp_c[13] = int'(pending_done);
    exp_c[14] = int'(legal && !is_j);
    foreach (obs_c[k]) obs_c[k] = 0;

    for (int i = 0; i < plan.size(); i++) begin
      logic [5:0] drv;
      drv = (plan[i] == DECODE || plan[i] == MEM_ADDR) ? op : 6'($urandom);
      step(rdy[i], drv);
      if (i == 0) begin
        tests++;
        if (retired_cnt !== model_cnt) begin
          fails++;
          $display("FAIL retired_cnt at fetch (op %b): got %h expected %h", op, retired_cnt, model_cnt);
        end
      end
      tests++;
      if (state !== plan[i]) begin
        fails++;
        $display("FAIL state seq op %b cycle %0d: got %0d expected %0d", op, i, state, plan[i]);
      end
      obs_c[0]  += int'(mem_read);
      obs_c[1]  += int'(mem_write);
      obs_c[2]  += int'(i_or_d);
      obs_c[3]  += int'(ir_write);
      obs_c[4]  += int'(pc_write);
      obs_c[5]  += int'(pc_write_cond);
      obs_c[6]  += int'(reg_write);
      obs_c[7]  += int'(mem_to_reg);
      obs_c[8]  += int'(reg_dst);
      obs_c[9]  += int'(alu_op === 2'b10);
      obs_c[10] += int'(alu_op === 2'b01);
      obs_c[11] += int'(pc_source === 2'b10);
      obs_c[12] += int'(illegal_op);
      obs_c[13] += int'(instr_done);
      obs_c[14] += int'(alu_src_a);
    end

    foreach (exp_c[k]) begin
      tests++;
      if (obs_c[k] !== exp_c[k]) begin
        fails++;
        $display("FAIL %s cycles (op %b sf %0d sm %0d): got %0d expected %0d",
                 names[k], op, sf, sm, obs_c[k], exp_c[k]);
      end
    end
    pending_done = legal;
    if (legal) model_cnt = model_cnt + 16'd1;
  endtask

  // One idle FETCH cycle that observes the retire pulse and count of the last instruction.
  task automatic check_tail();
    step(1'b0, 6'($urandom));
    tests++;
    if (state !== FETCH) begin
      fails++; $display("FAIL tail state: got %0d expected %0d", state, FETCH);
    end
    tests++;
    if (instr_done !== pending_done) begin
      fails++; $display("FAIL tail instr_done: got %b expected %b", instr_done, pending_done);
    end
    tests++;
    if (retired_cnt !== model_cnt) begin
      fails++; $display("FAIL tail retired_cnt: got %h expected %h", retired_cnt, model_cnt);
    end
    pending_done = 1'b0;
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    rst = 1'b1; mem_ready = 1'b1; instr_op = 6'($urandom);
    #1;
    tests++;
    if ({ctrl_bus(), instr_done, illegal_op} !== 18'd0) begin
      fails++; $display("FAIL reset outputs: got %h expected 0", {ctrl_bus(), instr_done, illegal_op});
    end
    tests++;
    if (retired_cnt !== 16'd0) begin
      fails++; $display("FAIL reset retired_cnt: got %h expected 0", retired_cnt);
    end
    @(posedge clk); #1;
    tests++;
    if (state !== FETCH) begin
      fails++; $display("FAIL reset state: got %0d expected %0d", state, FETCH);
    end
    rst = 1'b0; mem_ready = 1'b0;
    #1;
    model_cnt    = '0;
    pending_done = 1'b0;
  endtask

  task automatic test_lw();
    run_instr(OP_LW, 0, 0);
    check_tail();
  endtask

  task automatic test_sw_stall();
    run_instr(OP_SW, 0, 3);
    check_tail();
  endtask

  task automatic test_r_beq_j();
    test_reset();
    run_instr(OP_RTYPE, 0, 0);
    run_instr(OP_BEQ, 0, 0);
    run_instr(OP_J, 0, 0);
    check_tail();
    tests++;
    if (retired_cnt !== 16'd3) begin
      fails++; $display("FAIL r_beq_j retired_cnt: got %0d expected 3", retired_cnt);
    end
  endtask

  task automatic test_illegal();
    run_instr(6'b111111, 1, 0);
    check_tail();
  endtask

  task automatic test_reset_in_stall();
    step(1'b1, 6'($urandom));
    step(1'($urandom), OP_LW);
    step(1'($urandom), OP_LW);
    step(1'b0, 6'($urandom));
    step(1'b0, 6'($urandom));
    tests++;
    if (state !== MEM_RD || mem_read !== 1'b1) begin
      fails++; $display("FAIL stall setup: got state %0d mem_read %b expected %0d 1", state, mem_read, MEM_RD);
    end
    @(posedge clk); #1;
    rst = 1'b1; mem_ready = 1'b0;
    #1;
    tests++;
    if ({ctrl_bus(), instr_done, illegal_op, retired_cnt} !== 34'd0) begin
      fails++; $display("FAIL stall reset outputs: got %h expected 0", {ctrl_bus(), instr_done, illegal_op, retired_cnt});
    end
    step(1'b1, 6'($urandom));
    tests++;
    if (state !== FETCH) begin
      fails++; $display("FAIL stall reset state: got %0d expected %0d", state, FETCH);
    end
    tests++;
    if ({ctrl_bus(), instr_done, illegal_op, retired_cnt} !== 34'd0) begin
      fails++; $display("FAIL stall reset held outputs: got %h expected 0", {ctrl_bus(), instr_done, illegal_op, retired_cnt});
    end
    @(posedge clk); #1;
    rst = 1'b0; mem_ready = 1'b0;
    #1;
    tests++;
    if (instr_done !== 1'b0 || retired_cnt !== 16'd0) begin
      fails++; $display("FAIL after stall reset: got done %b cnt %h expected 0 0", instr_done, retired_cnt);
    end
    model_cnt    = '0;
    pending_done = 1'b0;
  endtask

  task automatic test_random();
    logic [5:0] ops[6] = '{OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_J, OP_ADDI};
    for (int n = 0; n < 40; n++) begin
      int r;
      logic [5:0] op;
      r  = $urandom_range(0, 6);
      op = (r == 6) ? 6'($urandom) : ops[r];
      run_instr(op, $urandom_range(0, 2), $urandom_range(0, 3));
    end
    check_tail();
  endtask

  task automatic test_wrap();
    test_reset();
    mem_ready = 1'b1;
    instr_op  = OP_ADDI;
    repeat (4 * 65535 - 1) @(posedge clk);
    #2;
    model_cnt    = 16'hFFFF;
    pending_done = 1'b1;
    run_instr(OP_ADDI, 0, 0);
    check_tail();
    tests++;
    if (retired_cnt !== 16'h0000) begin
      fails++; $display("FAIL wrap retired_cnt: got %h expected 0000", retired_cnt);
    end
  endtask

  initial begin
    rst = 1'b1; mem_ready = 1'b0; instr_op = '0;
    test_reset();
    test_lw();
    test_sw_stall();
    test_r_beq_j();
    test_illegal();
    test_reset_in_stall();
    test_random();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
